// File: rtl/speck_ks_round_decrypt_unit.sv
// SPECK128/128 building blocks: one key-expansion step and one decryption round,
// each behind its own start/finished handshake. The channels share clock and reset only.
module speck_ks_round_decrypt_unit #(
   parameter int unsigned BLOCK_SIZE = 64,
   parameter int unsigned KEY_SIZE   = 128,
   parameter int unsigned NR_ROUNDS  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // key-expansion channel
   input  logic                  ks_start,
   input  logic [BLOCK_SIZE-1:0] ks_round_ctr,
   input  logic [KEY_SIZE-1:0]   ks_key_in,
   output logic [KEY_SIZE-1:0]   ks_key_out,
   output logic                  ks_finished,
   output logic [3:0]            ks_state,
   // decrypt-round channel
   input  logic                  rd_start,
   input  logic [BLOCK_SIZE-1:0] rd_subkey,
   input  logic [KEY_SIZE-1:0]   rd_ciphertext,
   output logic [KEY_SIZE-1:0]   rd_plaintext,
   output logic                  rd_finished,
   output logic [3:0]            rd_state
);

   localparam int unsigned ALPHA = 8;
   localparam int unsigned BETA  = 3;

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      CALC = 4'd1,
      DONE = 4'd2
   } state_e;

   // Reject parameter sets that cannot form a valid word pair / round count.
   if (KEY_SIZE != 2 * BLOCK_SIZE || NR_ROUNDS == 0) begin : g_param_check
      $error("speck_ks_round_decrypt_unit: KEY_SIZE must be 2*BLOCK_SIZE and NR_ROUNDS nonzero");
   end

   function automatic logic [BLOCK_SIZE-1:0] ror(input logic [BLOCK_SIZE-1:0] x,
                                                 input int unsigned s);
      return (x >> s) | (x << (BLOCK_SIZE - s));
   endfunction

   function automatic logic [BLOCK_SIZE-1:0] rol(input logic [BLOCK_SIZE-1:0] x,
                                                 input int unsigned s);
      return (x << s) | (x >> (BLOCK_SIZE - s));
   endfunction

   // Round 0 passes the master key through so its upper word is round key 0.
   function automatic logic [KEY_SIZE-1:0] ks_step(input logic [BLOCK_SIZE-1:0] r,
                                                   input logic [KEY_SIZE-1:0]   kl);
      logic [BLOCK_SIZE-1:0] k;
      logic [BLOCK_SIZE-1:0] l;
      logic [BLOCK_SIZE-1:0] k_n;
      logic [BLOCK_SIZE-1:0] l_n;
      k   = kl[KEY_SIZE-1 -: BLOCK_SIZE];
      l   = kl[BLOCK_SIZE-1:0];
      l_n = (k + ror(l, ALPHA)) ^ (r - BLOCK_SIZE'(1));
      k_n = rol(k, BETA) ^ l_n;
      if (r == '0) begin
         return kl;
      end
      return KEY_SIZE'({k_n, l_n});
   endfunction

   // Inverse of the SPECK encryption round.
   function automatic logic [KEY_SIZE-1:0] rd_step(input logic [BLOCK_SIZE-1:0] k,
                                                   input logic [KEY_SIZE-1:0]   ct);
      logic [BLOCK_SIZE-1:0] x;
      logic [BLOCK_SIZE-1:0] y;
      logic [BLOCK_SIZE-1:0] x_n;
      logic [BLOCK_SIZE-1:0] y_n;
      x   = ct[KEY_SIZE-1 -: BLOCK_SIZE];
      y   = ct[BLOCK_SIZE-1:0];
      y_n = ror(x ^ y, BETA);
      x_n = rol((x ^ k) - y_n, ALPHA);
      return KEY_SIZE'({x_n, y_n});
   endfunction

   // ---------------- key-expansion channel ----------------
   state_e                ks_state_q, ks_state_d;
   logic [BLOCK_SIZE-1:0] ks_ctr_q,   ks_ctr_d;
   logic [KEY_SIZE-1:0]   ks_key_q,   ks_key_d;
   logic [KEY_SIZE-1:0]   ks_out_q,   ks_out_d;
   logic                  ks_fin_q,   ks_fin_d;

   // Key channel next-state: latch in IDLE/DONE, compute in CALC, hold in DONE.
   always_comb begin
      ks_state_d = ks_state_q;
      ks_ctr_d   = ks_ctr_q;
      ks_key_d   = ks_key_q;
      ks_out_d   = ks_out_q;
      ks_fin_d   = ks_fin_q;
      case (ks_state_q)
         IDLE: begin
            ks_fin_d = 1'b0;
            if (ks_start) begin
               ks_ctr_d   = ks_round_ctr;
               ks_key_d   = ks_key_in;
               ks_state_d = CALC;
            end
         end
         CALC: begin
            ks_out_d   = ks_step(ks_ctr_q, ks_key_q);
            ks_fin_d   = 1'b1;
            ks_state_d = DONE;
         end
         DONE: begin
            if (ks_start) begin
               ks_ctr_d   = ks_round_ctr;
               ks_key_d   = ks_key_in;
               ks_fin_d   = 1'b0;
               ks_state_d = CALC;
            end
         end
         default: begin
            ks_fin_d   = 1'b0;
            ks_state_d = IDLE;
         end
      endcase
   end

   // Key channel registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ks_state_q <= IDLE;
         ks_ctr_q   <= '0;
         ks_key_q   <= '0;
         ks_out_q   <= '0;
         ks_fin_q   <= 1'b0;
      end else begin
         ks_state_q <= ks_state_d;
         ks_ctr_q   <= ks_ctr_d;
         ks_key_q   <= ks_key_d;
         ks_out_q   <= ks_out_d;
         ks_fin_q   <= ks_fin_d;
      end
   end

   assign ks_key_out  = ks_out_q;
   assign ks_finished = ks_fin_q;
   assign ks_state    = 4'(ks_state_q);

   // ---------------- decrypt-round channel ----------------
   state_e                rd_state_q, rd_state_d;
   logic [BLOCK_SIZE-1:0] rd_k_q,     rd_k_d;
   logic [KEY_SIZE-1:0]   rd_ct_q,    rd_ct_d;
   logic [KEY_SIZE-1:0]   rd_out_q,   rd_out_d;
   logic                  rd_fin_q,   rd_fin_d;

   // Decrypt channel next-state: same handshake as the key channel.
   always_comb begin
      rd_state_d = rd_state_q;
      rd_k_d     = rd_k_q;
      rd_ct_d    = rd_ct_q;
      rd_out_d   = rd_out_q;
      rd_fin_d   = rd_fin_q;
      case (rd_state_q)
         IDLE: begin
            rd_fin_d = 1'b0;
            if (rd_start) begin
               rd_k_d     = rd_subkey;
               rd_ct_d    = rd_ciphertext;
               rd_state_d = CALC;
            end
         end
         CALC: begin
            rd_out_d   = rd_step(rd_k_q, rd_ct_q);
            rd_fin_d   = 1'b1;
            rd_state_d = DONE;
         end
         DONE: begin
            if (rd_start) begin
               rd_k_d     = rd_subkey;
               rd_ct_d    = rd_ciphertext;
               rd_fin_d   = 1'b0;
               rd_state_d = CALC;
            end
         end
         default: begin
            rd_fin_d   = 1'b0;
            rd_state_d = IDLE;
         end
      endcase
   end

   // Decrypt channel registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state_q <= IDLE;
         rd_k_q     <= '0;
         rd_ct_q    <= '0;
         rd_out_q   <= '0;
         rd_fin_q   <= 1'b0;
      end else begin
         rd_state_q <= rd_state_d;
         rd_k_q     <= rd_k_d;
         rd_ct_q    <= rd_ct_d;
         rd_out_q   <= rd_out_d;
         rd_fin_q   <= rd_fin_d;
      end
   end

   assign rd_plaintext = rd_out_q;
   assign rd_finished  = rd_fin_q;
   assign rd_state     = 4'(rd_state_q);

endmodule

// File: tb/tb_speck_ks_round_decrypt_unit.sv
// Self-checking bench for speck_ks_round_decrypt_unit: vector tables, scoreboard queues,
// handshake corner sequences, full SPECK128/128 decryption chain and mid-operation reset.
module tb_speck_ks_round_decrypt_unit;

   logic         clk;
   logic         rst_n;
   logic         ks_start;
   logic [63:0]  ks_round_ctr;
   logic [127:0] ks_key_in;
   logic [127:0] ks_key_out;
   logic         ks_finished;
   logic [3:0]   ks_state;
   logic         rd_start;
   logic [63:0]  rd_subkey;
   logic [127:0] rd_ciphertext;
   logic [127:0] rd_plaintext;
   logic         rd_finished;
   logic [3:0]   rd_state;

   int n_checks = 0;
   int n_fail   = 0;

   logic [127:0] ks_exp_q[$];
   logic [127:0] rd_exp_q[$];
   logic [127:0] ks_last;
   logic [127:0] rd_last;

   speck_ks_round_decrypt_unit #(
      .BLOCK_SIZE(64),
      .KEY_SIZE  (128),
      .NR_ROUNDS (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ks_start     (ks_start),
      .ks_round_ctr (ks_round_ctr),
      .ks_key_in    (ks_key_in),
      .ks_key_out   (ks_key_out),
      .ks_finished  (ks_finished),
      .ks_state     (ks_state),
      .rd_start     (rd_start),
      .rd_subkey    (rd_subkey),
      .rd_ciphertext(rd_ciphertext),
      .rd_plaintext (rd_plaintext),
      .rd_finished  (rd_finished),
      .rd_state     (rd_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   function automatic logic [63:0] rotr(input logic [63:0] x, input int s);
      logic [127:0] d;
      d = {x, x} >> s;
      return d[63:0];
   endfunction

   function automatic logic [63:0] rotl(input logic [63:0] x, input int s);
      return rotr(x, 64 - s);
   endfunction

   function automatic logic [127:0] ks_model(input logic [63:0] r, input logic [127:0] kl);
      logic [63:0] k, l, kp, lp;
      if (r == 64'd0) return kl;
      k  = kl[127:64];
      l  = kl[63:0];
      lp = (k + rotr(l, 8)) ^ (r - 64'd1);
      kp = rotl(k, 3) ^ lp;
      return {kp, lp};
   endfunction

   function automatic logic [127:0] rd_model(input logic [63:0] k, input logic [127:0] ct);
      logic [63:0] x, y, xp, yp;
      x  = ct[127:64];
      y  = ct[63:0];
      yp = rotr(x ^ y, 3);
      xp = rotl((x ^ k) - yp, 8);
      return {xp, yp};
   endfunction

   // ---------------- check helpers ----------------
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: expected event did not occur", name);
   endtask

   task automatic scramble();
      ks_round_ctr  = {$urandom, $urandom};
      ks_key_in     = {$urandom, $urandom, $urandom, $urandom};
      rd_subkey     = {$urandom, $urandom};
      rd_ciphertext = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Drive a key request (call at a negedge); expected result goes to the scoreboard.
   task automatic issue_ks(input logic [63:0] r, input logic [127:0] key);
      ks_round_ctr = r;
      ks_key_in    = key;
      ks_start     = 1'b1;
      ks_exp_q.push_back(ks_model(r, key));
   endtask

   task automatic issue_rd(input logic [63:0] k, input logic [127:0] ct);
      rd_subkey     = k;
      rd_ciphertext = ct;
      rd_start      = 1'b1;
      rd_exp_q.push_back(rd_model(k, ct));
   endtask

   // Drop start after one sampling edge, scramble inputs, then wait (bounded) for finished.
   task automatic collect(input bit use_ks, input bit use_rd);
      int cyc;
      bit ks_seen, rd_seen;
      logic [127:0] e;
      @(negedge clk);
      ks_start = 1'b0;
      rd_start = 1'b0;
      scramble();
      ks_seen = !use_ks;
      rd_seen = !use_rd;
      cyc = 1;
      while (!(ks_seen && rd_seen) && cyc <= 8) begin
         if (!ks_seen && ks_finished) begin
            ks_seen = 1'b1;
            chk("ks_latency", 128'(cyc), 128'd2);
            if (ks_exp_q.size() == 0) fail_now("ks_scoreboard_empty");
            else begin
               e = ks_exp_q.pop_front();
               ks_last = e;
               chk("ks_key_out", ks_key_out, e);
            end
         end
         if (!rd_seen && rd_finished) begin
            rd_seen = 1'b1;
            chk("rd_latency", 128'(cyc), 128'd2);
            if (rd_exp_q.size() == 0) fail_now("rd_scoreboard_empty");
            else begin
               e = rd_exp_q.pop_front();
               rd_last = e;
               chk("rd_plaintext", rd_plaintext, e);
            end
         end
         if (!(ks_seen && rd_seen)) begin
            @(negedge clk);
            cyc++;
         end
      end
      if (!ks_seen) fail_now("ks_finished_timeout");
      if (!rd_seen) fail_now("rd_finished_timeout");
   endtask

   // ---------------- vector tables ----------------
   typedef struct {
      logic [63:0]  r;
      logic [127:0] key;
      logic [127:0] exp;
   } ks_vec_t;

   typedef struct {
      logic [63:0]  k;
      logic [127:0] ct;
      logic [127:0] exp;
   } rd_vec_t;

   localparam logic [127:0] MASTER_KEY = 128'h0706050403020100_0f0e0d0c0b0a0908;
   localparam logic [127:0] CHAIN_CT   = 128'ha65d985179783265_7860fedf5c570d18;
   localparam logic [127:0] CHAIN_PT   = 128'h6c61766975716520_7469206564616d20;

   ks_vec_t     ks_tbl[4];
   rd_vec_t     rd_tbl[4];
   logic [63:0] rk[32];

   initial begin
      logic [127:0] cur;
      logic [127:0] exp_a, exp_b;
      logic [127:0] rnd_key;
      logic [63:0]  rnd_r;

      // Spec vectors plus model-derived random/boundary entries.
      ks_tbl[0] = '{64'd0, MASTER_KEY, MASTER_KEY};
      ks_tbl[1] = '{64'd1, MASTER_KEY, 128'h37253b31171d0309_0f1513110f0d0b09};
      rnd_key   = {$urandom, $urandom, $urandom, $urandom};
      rnd_r     = {$urandom, $urandom} | 64'd2;
      ks_tbl[2] = '{rnd_r, rnd_key, ks_model(rnd_r, rnd_key)};
      rnd_key   = {$urandom, $urandom, $urandom, $urandom};
      ks_tbl[3] = '{64'hffff_ffff_ffff_ffff, rnd_key, ks_model(64'hffff_ffff_ffff_ffff, rnd_key)};

      rd_tbl[0] = '{64'd0, 128'h0000000000000001_0000000000000000,
                    128'h00000000000001e0_2000000000000000};
      rd_tbl[1] = '{64'd0, 128'd0, 128'd0};
      rnd_key   = {$urandom, $urandom, $urandom, $urandom};
      rnd_r     = {$urandom, $urandom};
      rd_tbl[2] = '{rnd_r, rnd_key, rd_model(rnd_r, rnd_key)};
      rnd_key   = {128{1'b1}};
      rd_tbl[3] = '{64'hffff_ffff_ffff_ffff, rnd_key, rd_model(64'hffff_ffff_ffff_ffff, rnd_key)};

      // Reset state.
      rst_n = 1'b0;
      ks_start = 1'b0;
      rd_start = 1'b0;
      ks_round_ctr = '0;
      ks_key_in = '0;
      rd_subkey = '0;
      rd_ciphertext = '0;
      repeat (2) @(negedge clk);
      chk("reset_ks_key_out", ks_key_out, 128'd0);
      chk("reset_ks_finished", 128'(ks_finished), 128'd0);
      chk("reset_ks_state", 128'(ks_state), 128'd0);
      chk("reset_rd_plaintext", rd_plaintext, 128'd0);
      chk("reset_rd_finished", 128'(rd_finished), 128'd0);
      chk("reset_rd_state", 128'(rd_state), 128'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table vectors, each channel on its own; checks against table expectations too.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         issue_ks(ks_tbl[i].r, ks_tbl[i].key);
         collect(1'b1, 1'b0);
         chk("ks_table", ks_key_out, ks_tbl[i].exp);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         issue_rd(rd_tbl[i].k, rd_tbl[i].ct);
         collect(1'b0, 1'b1);
         chk("rd_table", rd_plaintext, rd_tbl[i].exp);
      end

      // Simultaneous starts on both channels.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         issue_ks(ks_tbl[i].r, ks_tbl[i].key);
         issue_rd(rd_tbl[i].k, rd_tbl[i].ct);
         collect(1'b1, 1'b1);
      end

      // Start held 3 sampling edges, inputs changed during CALC.
      @(negedge clk);
      exp_a = ks_model(64'd1, MASTER_KEY);
      ks_round_ctr = 64'd1;
      ks_key_in = MASTER_KEY;
      ks_start = 1'b1;
      @(negedge clk);
      chk("hold_calc_state", 128'(ks_state), 128'd1);
      chk("hold_calc_finished", 128'(ks_finished), 128'd0);
      rnd_key = {$urandom, $urandom, $urandom, $urandom};
      ks_round_ctr = 64'd5;
      ks_key_in = rnd_key;
      exp_b = ks_model(64'd5, rnd_key);
      @(negedge clk);
      chk("hold_done_state", 128'(ks_state), 128'd2);
      chk("hold_done_finished", 128'(ks_finished), 128'd1);
      chk("hold_calc_start_ignored", ks_key_out, exp_a);
      @(negedge clk);
      chk("hold_restart_state", 128'(ks_state), 128'd1);
      chk("hold_restart_finished", 128'(ks_finished), 128'd0);
      chk("hold_restart_out_held", ks_key_out, exp_a);
      ks_start = 1'b0;
      scramble();
      @(negedge clk);
      chk("hold_second_result", ks_key_out, exp_b);
      chk("hold_second_finished", 128'(ks_finished), 128'd1);
      repeat (3) @(negedge clk);
      chk("done_stable_state", 128'(ks_state), 128'd2);
      chk("done_stable_out", ks_key_out, exp_b);
      chk("done_stable_finished", 128'(ks_finished), 128'd1);

      // Decrypt: start kept high only across the CALC edge, then dropped: no restart.
      @(negedge clk);
      exp_a = rd_model(64'h0123_4567_89ab_cdef, CHAIN_CT);
      rd_subkey = 64'h0123_4567_89ab_cdef;
      rd_ciphertext = CHAIN_CT;
      rd_start = 1'b1;
      @(negedge clk);
      rd_subkey = {$urandom, $urandom};
      rd_ciphertext = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      rd_start = 1'b0;
      chk("pulse_done_state", 128'(rd_state), 128'd2);
      chk("pulse_result", rd_plaintext, exp_a);
      @(negedge clk);
      chk("pulse_no_restart_state", 128'(rd_state), 128'd2);
      chk("pulse_no_restart_out", rd_plaintext, exp_a);

      // Full chain: 32 key steps, then 32 decrypt rounds with keys in reverse order.
      cur = MASTER_KEY;
      for (int r = 0; r < 32; r++) begin
         @(negedge clk);
         issue_ks(64'(r), cur);
         collect(1'b1, 1'b0);
         cur = ks_last;
         rk[r] = cur[127:64];
      end
      chk("chain_rk0", 128'(rk[0]), 128'h0706050403020100);
      chk("chain_rk1", 128'(rk[1]), 128'h37253b31171d0309);
      cur = CHAIN_CT;
      for (int r = 31; r >= 0; r--) begin
         @(negedge clk);
         issue_rd(rk[r], cur);
         collect(1'b0, 1'b1);
         cur = rd_last;
      end
      chk("chain_plaintext", cur, CHAIN_PT);
      chk("chain_dut_plaintext", rd_plaintext, CHAIN_PT);

      // Reset asserted while both channels are in CALC.
      @(negedge clk);
      ks_round_ctr = 64'd3;
      ks_key_in = {$urandom, $urandom, $urandom, $urandom};
      ks_start = 1'b1;
      rd_subkey = {$urandom, $urandom};
      rd_ciphertext = {$urandom, $urandom, $urandom, $urandom};
      rd_start = 1'b1;
      @(negedge clk);
      chk("pre_reset_ks_state", 128'(ks_state), 128'd1);
      chk("pre_reset_rd_state", 128'(rd_state), 128'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_ks_finished", 128'(ks_finished), 128'd0);
      chk("abort_ks_state", 128'(ks_state), 128'd0);
      chk("abort_ks_key_out", ks_key_out, 128'd0);
      chk("abort_rd_finished", 128'(rd_finished), 128'd0);
      chk("abort_rd_state", 128'(rd_state), 128'd0);
      chk("abort_rd_plaintext", rd_plaintext, 128'd0);
      ks_start = 1'b0;
      rd_start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_ks_idle", 128'(ks_state), 128'd0);
      chk("post_reset_rd_idle", 128'(rd_state), 128'd0);

      // Operation after reset recovery.
      @(negedge clk);
      issue_ks(ks_tbl[1].r, ks_tbl[1].key);
      issue_rd(rd_tbl[0].k, rd_tbl[0].ct);
      collect(1'b1, 1'b1);

      if (ks_exp_q.size() != 0) fail_now("ks_scoreboard_leftover");
      if (rd_exp_q.size() != 0) fail_now("rd_scoreboard_leftover");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
